counter_monitor: RTL and testbench
==================================

# counter_monitor

Passive checker on the consumer side of the 8-bit counter's `count`/`overflow` interface. It samples the enable it drives, plus the counter outputs, on every clock. It predicts each next value, flags any divergence, captures the first failure, and counts observed wrap-arounds. It sits beside the counter in demo and self-checking benches, and its outputs are dumped to VCD alongside the counter.

## Interface
- `WIDTH`, 8: counter data width; maximum value is 2^WIDTH-1.
- `WRAP_W`, 16: width of the wrap counter.
- `ERR_W`, 8: width of the error counter.
- `STOP_ON_ERROR`, 0: 1 = halt checking at the first mismatch; 0 = keep checking.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `enable`, in, 1: the same enable the counter sees.
- `count`, in, WIDTH: counter output under check.
- `overflow`, in, 1: counter overflow flag under check.
- `clear_err`, in, 1: synchronous; clears error state and resynchronises.
- `active`, out, 1: 1 while in TRACK.
- `err`, out, 1: sticky; set on the first mismatch.
- `err_cnt`, out, ERR_W: number of mismatching cycles, saturating.
- `err_kind`, out, 2: at the first error, bit0 = count mismatch, bit1 = overflow mismatch.
- `first_exp`, out, WIDTH: expected count at the first error.
- `first_act`, out, WIDTH: observed count at the first error.
- `wrap_count`, out, WRAP_W: number of checked wrap-arounds, saturating.

## Operation
- Registered previous sample: `p_en`, `p_cnt`, `p_ovf`, updated every edge in IDLE and TRACK.
- Expected values at the current edge:
  - `exp_cnt` = `p_en` ? (`p_cnt`+1) mod 2^WIDTH : `p_cnt`.
  - `exp_ovf` = `p_en` ? (`p_cnt` == max) : `p_ovf`.
- Mismatch = (`count` != `exp_cnt`) or (`overflow` != `exp_ovf`); evaluated only in TRACK.
- State machine (IDLE / TRACK / HALT):
  - IDLE: capture the sample, no check; next state TRACK.
  - TRACK: check every edge. On mismatch with STOP_ON_ERROR=1, go to HALT; otherwise stay in TRACK.
  - HALT: no capture, no check; all outputs frozen. Leave only via `clear_err` or `reset`.
  - `clear_err` from any state: next state IDLE.
- On a mismatch in TRACK:
  - `err_cnt` increments, saturating at 2^ERR_W-1.
  - If `err` was 0: set `err`, and load `err_kind`, `first_exp` = `exp_cnt`, `first_act` = `count`.
  - Later errors do not overwrite the first-error fields.
- Resync after a mismatch: the previous sample always takes the observed values. One corrupted sample therefore yields two mismatches, on entry and on exit of the glitch.
- Wrap: in TRACK, `p_en`=1 and `p_cnt`==max with no mismatch increments `wrap_count`, saturating at 2^WRAP_W-1.
- `clear_err` zeroes `err`, `err_cnt`, `err_kind`, `first_exp`, `first_act`. `wrap_count` is preserved.
- `clear_err` coinciding with a mismatch: clear wins and nothing is recorded.

## Timing
- Reset values:
  - State IDLE.
  - `active`=0, `err`=0, `err_cnt`=0, `err_kind`=0, `first_exp`=0, `first_act`=0, `wrap_count`=0.
  - `p_en`=0, `p_cnt`=0, `p_ovf`=0.
- All outputs are registered. A mismatch sampled at edge k is visible on `err`/`err_cnt` after edge k.
- First check happens at the second rising edge after `reset` deasserts: edge 1 is IDLE capture, edge 2 is the first TRACK check.
- `active` rises after edge 1 and falls the edge after entering HALT or taking `clear_err`.
- Monitor and counter share `clk` and `reset`. Reset asserted mid-run returns the monitor to IDLE asynchronously, so no false error is raised when the counter's count drops to 0.
- Holding `enable`=0 indefinitely is legal: count and overflow must hold, and no wrap is counted.
- Throughput: one check per cycle, no backpressure, no gaps.

## Test plan
- Reset, then 300 cycles with `enable`=1 and a clean counter:
  - `active`=1 from cycle 1, `err`=0.
  - `wrap_count`=1 after count 0xFF→0x00, with `overflow`=1 for exactly one sample.
- Random `enable` (~50%) for 2000 cycles: `err`=0, `err_cnt`=0, and `wrap_count` equals the number of enabled 0xFF→0x00 transitions.
- Force the observed `count` to 0x55 for one cycle when 0x11 is expected:
  - `err`=1, `err_kind`=01, `first_exp`=0x11, `first_act`=0x55.
  - `err_cnt`=2: the next sample 0x12 is checked against expected 0x56.
- Same injection with STOP_ON_ERROR=1: HALT, `active`=0, `err_cnt`=1; outputs unchanged for 50 further cycles.
- Pulse `clear_err` in HALT:
  - Error fields go to 0 and IDLE is entered; `wrap_count` is kept.
  - Checking resumes 2 edges later.
  - `clear_err` coincident with an injected mismatch leaves `err`=0.
- Assert `reset` mid-run at count 0x80: all outputs return to 0. No error is raised once counting restarts from 0.

Source files
------------

// File: rtl/counter_monitor.sv
// ---------------------------------------------------------------------------
// counter_monitor
//
// Passive checker that sits on the consumer side of an up-counter's
// count/overflow interface. Every rising edge it samples the enable it drives
// together with the counter outputs, predicts what the counter should show
// next, and records any divergence. The first failure is captured in detail;
// later failures are only counted. Checked wrap-arounds are counted as well.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   reset       in   asynchronous, active-high
//   enable      in   the enable the counter under check sees
//   count       in   [WIDTH-1:0] counter value under check
//   overflow    in   counter overflow flag under check
//   clear_err   in   synchronous; clears error state and resynchronises
//   active      out  1 while tracking (checking every edge)
//   err         out  sticky, set on the first mismatch
//   err_cnt     out  [ERR_W-1:0] mismatching cycles, saturating
//   err_kind    out  [1:0] first error: bit0 count mismatch, bit1 overflow
//   first_exp   out  [WIDTH-1:0] expected count at the first error
//   first_act   out  [WIDTH-1:0] observed count at the first error
//   wrap_count  out  [WRAP_W-1:0] checked wrap-arounds, saturating
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | capture one sample to seed the prediction, no check
// S_TRACK | check every edge against the prediction, capture every edge
// S_HALT  | stopped at an error (STOP_ON_ERROR=1); nothing changes
// ---------------------------------------------------------------------------
module counter_monitor #(
    parameter int WIDTH         = 8,
    parameter int WRAP_W        = 16,
    parameter int ERR_W         = 8,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  count,
    input  logic              overflow,
    input  logic              clear_err,
    output logic              active,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        err_kind,
    output logic [WIDTH-1:0]  first_exp,
    output logic [WIDTH-1:0]  first_act,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // previous sample
    logic             p_en;
    logic [WIDTH-1:0] p_cnt;
    logic             p_ovf;

    // prediction and comparison
    logic [WIDTH-1:0] exp_cnt;
    logic             exp_ovf;
    logic             cnt_mis;
    logic             ovf_mis;
    logic             mismatch;
    logic             wrap_hit;
    logic             capture;

    // next values of the registered outputs
    logic              active_nxt;
    logic              err_nxt;
    logic [ERR_W-1:0]  err_cnt_nxt;
    logic [1:0]        err_kind_nxt;
    logic [WIDTH-1:0]  first_exp_nxt;
    logic [WIDTH-1:0]  first_act_nxt;
    logic [WRAP_W-1:0] wrap_count_nxt;

    // -----------------------------------------------------------------------
    // Prediction of the current sample from the previous one. With the
    // enable low the counter must simply hold both count and overflow.
    // -----------------------------------------------------------------------
    always_comb begin
        exp_cnt  = p_en ? (p_cnt + WIDTH'(1)) : p_cnt;
        exp_ovf  = p_en ? (p_cnt == CNT_MAX) : p_ovf;
        cnt_mis  = (count != exp_cnt);
        ovf_mis  = (overflow != exp_ovf);
        mismatch = (state == S_TRACK) && (cnt_mis || ovf_mis);
        // A wrap is only credited when the step that produced it checked clean
        // and no clear is resynchronising the monitor on the same edge.
        wrap_hit = (state == S_TRACK) && p_en && (p_cnt == CNT_MAX)
                   && !mismatch && !clear_err;
        capture  = (state != S_HALT);
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (clear_err) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_TRACK;
                S_TRACK: begin
                    if (STOP_ON_ERROR && mismatch) begin
                        state_nxt = S_HALT;
                    end
                end
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        active_nxt     = (state_nxt == S_TRACK);
        err_nxt        = err;
        err_cnt_nxt    = err_cnt;
        err_kind_nxt   = err_kind;
        first_exp_nxt  = first_exp;
        first_act_nxt  = first_act;
        wrap_count_nxt = wrap_count;

        if (clear_err) begin
            // clear takes precedence over anything observed on this edge
            err_nxt       = 1'b0;
            err_cnt_nxt   = '0;
            err_kind_nxt  = 2'b00;
            first_exp_nxt = '0;
            first_act_nxt = '0;
        end else if (mismatch) begin
            if (err_cnt != ERR_MAX) begin
                err_cnt_nxt = err_cnt + ERR_W'(1);
            end
            if (!err) begin
                err_nxt       = 1'b1;
                err_kind_nxt  = {ovf_mis, cnt_mis};
                first_exp_nxt = exp_cnt;
                first_act_nxt = count;
            end
        end

        if (wrap_hit && (wrap_count != WRAP_MAX)) begin
            wrap_count_nxt = wrap_count + WRAP_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Registers: previous sample and outputs.
    // The previous sample always takes the observed values, even after a
    // mismatch, so a single corrupted sample shows up as two mismatches.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_en       <= 1'b0;
            p_cnt      <= '0;
            p_ovf      <= 1'b0;
            active     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            err_kind   <= 2'b00;
            first_exp  <= '0;
            first_act  <= '0;
            wrap_count <= '0;
        end else begin
            if (capture) begin
                p_en  <= enable;
                p_cnt <= count;
                p_ovf <= overflow;
            end
            active     <= active_nxt;
            err        <= err_nxt;
            err_cnt    <= err_cnt_nxt;
            err_kind   <= err_kind_nxt;
            first_exp  <= first_exp_nxt;
            first_act  <= first_act_nxt;
            wrap_count <= wrap_count_nxt;
        end
    end

endmodule

// File: tb/tb_counter_monitor.sv
// ---------------------------------------------------------------------------
// Bench for counter_monitor. A clean 8-bit counter is modelled here and its
// outputs (optionally corrupted) drive two monitors: one that keeps checking
// and one that halts at the first error. A behavioural model of the monitor
// predicts all outputs of both instances.
// ---------------------------------------------------------------------------
module tb_counter_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  count = 8'h00;
    logic        overflow = 1'b0;
    logic        clear_err = 1'b0;

    logic        d0_active, d0_err;
    logic [7:0]  d0_err_cnt, d0_first_exp, d0_first_act;
    logic [1:0]  d0_err_kind;
    logic [15:0] d0_wrap;
    logic        d1_active, d1_err;
    logic [7:0]  d1_err_cnt, d1_first_exp, d1_first_act;
    logic [1:0]  d1_err_kind;
    logic [15:0] d1_wrap;

    always #5 clk = ~clk;

    counter_monitor #(.WIDTH(8), .WRAP_W(16), .ERR_W(8), .STOP_ON_ERROR(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .count(count),
        .overflow(overflow), .clear_err(clear_err),
        .active(d0_active), .err(d0_err), .err_cnt(d0_err_cnt),
        .err_kind(d0_err_kind), .first_exp(d0_first_exp),
        .first_act(d0_first_act), .wrap_count(d0_wrap)
    );

    counter_monitor #(.WIDTH(8), .WRAP_W(16), .ERR_W(8), .STOP_ON_ERROR(1'b1)) dut_h (
        .clk(clk), .reset(reset), .enable(enable), .count(count),
        .overflow(overflow), .clear_err(clear_err),
        .active(d1_active), .err(d1_err), .err_cnt(d1_err_cnt),
        .err_kind(d1_err_kind), .first_exp(d1_first_exp),
        .first_act(d1_first_act), .wrap_count(d1_wrap)
    );

    // {active, err, err_cnt, err_kind, first_exp, first_act, wrap_count}
    logic [43:0] obs [2];
    assign obs[0] = {d0_active, d0_err, d0_err_cnt, d0_err_kind, d0_first_exp, d0_first_act, d0_wrap};
    assign obs[1] = {d1_active, d1_err, d1_err_cnt, d1_err_kind, d1_first_exp, d1_first_act, d1_wrap};

    int checks = 0;
    int failures = 0;

    // clean counter
    int c_cnt = 0;
    bit c_ovf = 1'b0;

    // independent wrap tally: enabled samples showing 0xFF
    bit t_en = 1'b0;
    int t_cnt = 0;
    int wraps_seen = 0;

    // monitor model; mode: 0 seeding, 1 checking, 2 halted
    int m_mode [2];
    bit m_pen  [2];
    int m_pcnt [2];
    bit m_povf [2];
    bit m_err  [2];
    int m_ecnt [2];
    int m_kind [2];
    int m_fexp [2];
    int m_fact [2];
    int m_wrap [2];
    bit m_stop [2] = '{1'b0, 1'b1};

    function automatic logic [43:0] exp_vec(input int i);
        return {(m_mode[i] == 1), m_err[i], 8'(m_ecnt[i]), 2'(m_kind[i]),
                8'(m_fexp[i]), 8'(m_fact[i]), 16'(m_wrap[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_pen[i] = 0; m_pcnt[i] = 0; m_povf[i] = 0;
            m_err[i] = 0; m_ecnt[i] = 0; m_kind[i] = 0; m_fexp[i] = 0;
            m_fact[i] = 0; m_wrap[i] = 0;
        end
        c_cnt = 0; c_ovf = 0; t_en = 0; t_cnt = 0;
    endtask

    task automatic model_edge(input int i, input bit en, input int cnt, input bit ovf, input bit clr);
        int  e_cnt;
        bit  e_ovf;
        bit  bad;
        int  kind;
        bad = 0;
        if (m_mode[i] != 2) begin
            if (m_mode[i] == 1) begin
                e_cnt = m_pen[i] ? (m_pcnt[i] + 1) % 256 : m_pcnt[i];
                e_ovf = m_pen[i] ? (m_pcnt[i] == 255) : m_povf[i];
                kind  = ((ovf != e_ovf) ? 2 : 0) + ((cnt != e_cnt) ? 1 : 0);
                bad   = (kind != 0);
                if (!clr) begin
                    if (bad) begin
                        if (m_ecnt[i] < 255) m_ecnt[i]++;
                        if (!m_err[i]) begin
                            m_err[i] = 1; m_kind[i] = kind; m_fexp[i] = e_cnt; m_fact[i] = cnt;
                        end
                    end else if (m_pen[i] && m_pcnt[i] == 255 && m_wrap[i] < 65535) begin
                        m_wrap[i]++;
                    end
                end
            end
            m_pen[i] = en; m_pcnt[i] = cnt; m_povf[i] = ovf;
        end
        if (clr) begin
            m_err[i] = 0; m_ecnt[i] = 0; m_kind[i] = 0; m_fexp[i] = 0; m_fact[i] = 0;
            m_mode[i] = 0;
        end else if (m_mode[i] == 0) begin
            m_mode[i] = 1;
        end else if (m_mode[i] == 1 && bad && m_stop[i]) begin
            m_mode[i] = 2;
        end
    endtask

    // one clock: drive at negedge, advance models at posedge, return #1 later
    task automatic step(input bit en, input bit inj, input logic [7:0] inj_val, input bit clr);
        int obs_cnt;
        @(negedge clk);
        enable    = en;
        count     = inj ? inj_val : 8'(c_cnt);
        overflow  = c_ovf;
        clear_err = clr;
        obs_cnt   = int'(count);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, en, obs_cnt, c_ovf, clr);
        if (t_en && t_cnt == 255) wraps_seen++;
        t_en = en; t_cnt = obs_cnt;
        if (en) begin
            c_ovf = (c_cnt == 255);
            c_cnt = (c_cnt + 1) % 256;
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 44'h0) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%h want=%h", i, obs[i], 44'h0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_count_run();
        for (int n = 0; n < 300; n++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL count_run cyc%0d dut%0d got=%h want=%h", n, i, obs[i], exp_vec(i));
                end
            end
            if (n == 0) begin
                checks++;
                if (d0_active !== 1'b1 || d1_active !== 1'b1) begin
                    failures++;
                    $display("FAIL active_after_edge1 got=%b%b want=11", d0_active, d1_active);
                end
            end
        end
        checks++;
        if (d0_wrap !== 16'd1 || d1_wrap !== 16'd1 || d0_err !== 1'b0 || d1_err !== 1'b0) begin
            failures++;
            $display("FAIL count_run_wrap wrap=%0d/%0d err=%b%b want wrap=1 err=0", d0_wrap, d1_wrap, d0_err, d1_err);
        end
    endtask

    task automatic test_random_enable();
        int base;
        base = wraps_seen;
        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL random_en cyc%0d dut%0d got=%h want=%h", n, i, obs[i], exp_vec(i));
                end
            end
        end
        checks++;
        if (d0_err !== 1'b0 || d0_err_cnt !== 8'd0 || d0_wrap !== 16'(1 + wraps_seen - base)) begin
            failures++;
            $display("FAIL random_en_summary err=%b err_cnt=%0d wrap=%0d want err=0 err_cnt=0 wrap=%0d",
                     d0_err, d0_err_cnt, d0_wrap, 1 + wraps_seen - base);
        end
    endtask

    task automatic test_inject();
        int guard;
        guard = 0;
        while (c_cnt != 8'h11 && guard < 600) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            guard++;
        end
        checks++;
        if (c_cnt != 8'h11) begin
            failures++;
            $display("FAIL inject_reach_0x11 got=%0h want=11", c_cnt);
        end
        step(1'b1, 1'b1, 8'h55, 1'b0);
        checks++;
        if (d0_err !== 1'b1 || d0_err_kind !== 2'b01 || d0_first_exp !== 8'h11 || d0_first_act !== 8'h55 || d0_err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL inject_first got err=%b kind=%b exp=%h act=%h cnt=%0d want 1 01 11 55 1",
                     d0_err, d0_err_kind, d0_first_exp, d0_first_act, d0_err_cnt);
        end
        checks++;
        if (d1_active !== 1'b0 || d1_err !== 1'b1 || d1_err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL halt_entry got active=%b err=%b cnt=%0d want 0 1 1", d1_active, d1_err, d1_err_cnt);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (d0_err_cnt !== 8'd2 || d0_first_exp !== 8'h11 || d0_first_act !== 8'h55) begin
            failures++;
            $display("FAIL inject_second got cnt=%0d exp=%h act=%h want 2 11 55", d0_err_cnt, d0_first_exp, d0_first_act);
        end
        for (int n = 0; n < 50; n++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL after_inject cyc%0d dut%0d got=%h want=%h", n, i, obs[i], exp_vec(i));
                end
            end
        end
        checks++;
        if (d1_active !== 1'b0 || d1_err_cnt !== 8'd1 || d1_first_exp !== 8'h11 || d1_first_act !== 8'h55 || d1_err_kind !== 2'b01) begin
            failures++;
            $display("FAIL halt_frozen got active=%b cnt=%0d exp=%h act=%h kind=%b want 0 1 11 55 01",
                     d1_active, d1_err_cnt, d1_first_exp, d1_first_act, d1_err_kind);
        end
    endtask

    task automatic test_clear_err();
        int wrap_h;
        wrap_h = m_wrap[1];
        step(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                failures++;
                $display("FAIL clear_model dut%0d got=%h want=%h", i, obs[i], exp_vec(i));
            end
        end
        checks++;
        if (d1_active !== 1'b0 || d1_err !== 1'b0 || d1_err_cnt !== 8'd0 || d1_err_kind !== 2'b00 ||
            d1_first_exp !== 8'h00 || d1_first_act !== 8'h00 || d1_wrap !== 16'(wrap_h) || d0_err !== 1'b0) begin
            failures++;
            $display("FAIL clear_fields got active=%b err=%b cnt=%0d wrap=%0d want 0 0 0 %0d",
                     d1_active, d1_err, d1_err_cnt, d1_wrap, wrap_h);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (d1_active !== 1'b1 || d1_err !== 1'b0) begin
            failures++;
            $display("FAIL clear_resume got active=%b err=%b want 1 0", d1_active, d1_err);
        end
        // first edge of checking after the clear must catch a glitch
        step(1'b1, 1'b1, 8'(c_cnt) ^ 8'h80, 1'b0);
        checks++;
        if (d0_err !== 1'b1 || d1_err !== 1'b1 || d1_err_cnt !== 8'd1 || d1_err_kind !== 2'b01) begin
            failures++;
            $display("FAIL check_resumed got err=%b%b cnt=%0d kind=%b want 11 1 01", d0_err, d1_err, d1_err_cnt, d1_err_kind);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        // clear coinciding with a mismatch in tracking: nothing recorded
        step(1'b1, 1'b1, 8'(c_cnt) ^ 8'h3C, 1'b1);
        checks++;
        if (d0_err !== 1'b0 || d1_err !== 1'b0 || d0_err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clear_vs_mismatch got err=%b%b cnt=%0d want 00 0", d0_err, d1_err, d0_err_cnt);
        end
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i) || obs[i][42] !== 1'b0) begin
                    failures++;
                    $display("FAIL after_clear cyc%0d dut%0d got=%h want=%h", n, i, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (c_cnt != 8'h80 && guard < 600) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            guard++;
        end
        checks++;
        if (c_cnt != 8'h80) begin
            failures++;
            $display("FAIL mid_reset_reach_0x80 got=%0h want=80", c_cnt);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        count = 8'h00; overflow = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 44'h0) begin
                failures++;
                $display("FAIL mid_reset_clear dut%0d got=%h want=%h", i, obs[i], 44'h0);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i) || obs[i][42] !== 1'b0) begin
                    failures++;
                    $display("FAIL after_reset cyc%0d dut%0d got=%h want=%h", n, i, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_run();
        test_random_enable();
        test_inject();
        test_clear_err();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
